ps2_kbd_fifo_ctrl: RTL and testbench

//  PS/2 keyboard controller, second generation. Decodes set-2 scan codes and tracks

---
 rtl/ps2_kbd_fifo_ctrl_pkg.sv | 34 +++
 rtl/ps2_kbd_fifo_ctrl_if.sv | 12 +
 rtl/kbd_event_fifo.sv | 45 ++++
 rtl/ps2_rx.sv | 48 ++++
 rtl/ps2_kbd_fifo_ctrl.sv | 166 ++++++++++++++++
 tb/tb_ps2_kbd_fifo_ctrl.sv | 226 ++++++++++++++++++++++
 6 files changed

// File: rtl/ps2_kbd_fifo_ctrl_pkg.sv
// Shared definitions for the PS/2 keyboard controller: bus register map, scan-code
// constants, decode state encodings and the queued event layout.
package ps2_kbd_fifo_ctrl_pkg;

    localparam logic [7:0] REG_STATUS  = 8'h00;
    localparam logic [7:0] REG_CODE    = 8'h01;
    localparam logic [7:0] REG_FLAGS   = 8'h02;
    localparam logic [7:0] REG_CONTROL = 8'h03;

    localparam logic [7:0] PFX_EXT    = 8'hE0;
    localparam logic [7:0] PFX_BRK    = 8'hF0;
    localparam logic [7:0] KEY_LALT   = 8'h11;
    localparam logic [7:0] KEY_LSHIFT = 8'h12;
    localparam logic [7:0] KEY_LCTRL  = 8'h14;
    localparam logic [7:0] KEY_CAPS   = 8'h58;
    localparam logic [7:0] KEY_RSHIFT = 8'h59;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_EXT     = 2'd1;
    localparam logic [1:0] ST_BRK     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

    typedef struct packed {
        logic       ext;
        logic [7:0] code;
    } kbd_evt_t;

    // Keyboard housekeeping bytes (error, BAT ok, ack, resend) carry no key.
    function automatic logic is_ignored(input logic [7:0] c);
        return (c == 8'h00) || (c == 8'hAA) || (c == 8'hFA) ||
               (c == 8'hFE) || (c == 8'hFF);
    endfunction

endpackage

// File: rtl/ps2_kbd_fifo_ctrl_if.sv
// CPU I/O bus window of the keyboard controller.
interface ps2_kbd_fifo_ctrl_if;
    logic       en_i;
    logic       we_i;
    logic [7:0] addr_i;
    logic [7:0] din_i;
    logic [7:0] dout_o;
    logic       irq_o;

    modport master (output en_i, we_i, addr_i, din_i, input dout_o, irq_o);
    modport slave  (input en_i, we_i, addr_i, din_i, output dout_o, irq_o);
endinterface

// File: rtl/kbd_event_fifo.sv
// Synchronous FIFO with wrap-bit pointers. Pop on empty and push on full (without
// a same-cycle pop) are ignored; flush beats everything.
module kbd_event_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] head,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr, rd_ptr;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end
endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver on already-synchronised lines: start, 8 data
// bits LSB first, odd parity, stop. Bad parity or stop drops the byte.
module ps2_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_din,
    output logic       rx_stb,
    output logic [7:0] rx_code
);
    logic       clk_q;
    logic       busy;
    logic [3:0] cnt;
    logic [8:0] shreg;
    logic       fall;

    assign fall = clk_q & ~ps2_clk;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_q   <= 1'b1;
            busy    <= 1'b0;
            cnt     <= '0;
            shreg   <= '0;
            rx_stb  <= 1'b0;
            rx_code <= '0;
        end else begin
            clk_q  <= ps2_clk;
            rx_stb <= 1'b0;
            if (fall) begin
                if (!busy) begin
                    // Only a low start bit opens a frame, which is how we resync.
                    busy <= ~ps2_din;
                    cnt  <= '0;
                end else if (cnt == 4'd9) begin
                    busy <= 1'b0;
                    if (ps2_din && (^shreg)) begin
                        rx_stb  <= 1'b1;
                        rx_code <= shreg[7:0];
                    end
                end else begin
                    shreg <= {ps2_din, shreg[8:1]};
                    cnt   <= cnt + 4'd1;
                end
            end
        end
    end
endmodule

// File: rtl/ps2_kbd_fifo_ctrl.sv
// PS/2 set-2 keyboard controller: scan-code decode with modifier/caps tracking,
// queued make events, bus register window and level interrupt.
module ps2_kbd_fifo_ctrl
    import ps2_kbd_fifo_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8,
    parameter bit IRQ_EN_RST = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              ps2_clk_i,
    input  logic              ps2_din_i,
    ps2_kbd_fifo_ctrl_if.slave bus
);
    logic [1:0] clk_sync, din_sync;
    logic       rx_stb;
    logic [7:0] rx_code;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            clk_sync <= 2'b11;
            din_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            din_sync <= {din_sync[0], ps2_din_i};
        end
    end

    ps2_rx u_rx (
        .clk     (clk_i),
        .rst     (rst_i),
        .ps2_clk (clk_sync[1]),
        .ps2_din (din_sync[1]),
        .rx_stb  (rx_stb),
        .rx_code (rx_code)
    );

    // Decode: one step per received byte.
    logic [1:0] st, st_nxt;
    logic       mk, brk, ev_ext, fake, is_mod, push;

    always_comb begin
        st_nxt = st;
        mk     = 1'b0;
        brk    = 1'b0;
        ev_ext = 1'b0;
        if (rx_stb) begin
            case (st)
                ST_IDLE: begin
                    if (rx_code == PFX_EXT)      st_nxt = ST_EXT;
                    else if (rx_code == PFX_BRK) st_nxt = ST_BRK;
                    else if (!is_ignored(rx_code)) mk = 1'b1;
                end
                ST_EXT: begin
                    if (rx_code == PFX_BRK) st_nxt = ST_EXT_BRK;
                    else if (rx_code != PFX_EXT) begin
                        mk     = 1'b1;
                        ev_ext = 1'b1;
                        st_nxt = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    brk    = 1'b1;
                    st_nxt = ST_IDLE;
                end
                default: begin
                    brk    = 1'b1;
                    ev_ext = 1'b1;
                    st_nxt = ST_IDLE;
                end
            endcase
        end
    end

    assign fake   = ev_ext & ((rx_code == KEY_LSHIFT) | (rx_code == KEY_RSHIFT));
    assign is_mod = (rx_code == KEY_LCTRL) | (rx_code == KEY_LALT) |
                    (~ev_ext & ((rx_code == KEY_LSHIFT) | (rx_code == KEY_RSHIFT)));
    assign push   = mk & ~fake & ~is_mod;

    logic lshift, rshift, lctrl, rctrl, lalt, ralt, caps, caps_held;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            st <= ST_IDLE;
            {lshift, rshift, lctrl, rctrl, lalt, ralt, caps, caps_held} <= '0;
        end else begin
            st <= st_nxt;
            // Within this branch brk == ~mk, so each flag simply follows mk.
            if ((mk || brk) && !fake) begin
                if (ev_ext) begin
                    if (rx_code == KEY_LCTRL) rctrl <= mk;
                    if (rx_code == KEY_LALT)  ralt  <= mk;
                end else begin
                    if (rx_code == KEY_LSHIFT) lshift <= mk;
                    if (rx_code == KEY_RSHIFT) rshift <= mk;
                    if (rx_code == KEY_LCTRL)  lctrl  <= mk;
                    if (rx_code == KEY_LALT)   lalt   <= mk;
                    if (rx_code == KEY_CAPS) begin
                        caps_held <= mk;
                        if (mk && !caps_held) caps <= ~caps;
                    end
                end
            end
        end
    end

    // Event queue and register window.
    logic       rd_sel, wr_ctl, pop, flush, ovf_clr, ovf_set;
    logic       full, empty, ovf, irq_en, irq_q;
    logic [8:0] head_raw;
    kbd_evt_t   head, ev;
    logic [7:0] status, rd_data, dout_q;
    logic [4:0] unused_din;

    assign unused_din = bus.din_i[7:3];
    assign rd_sel  = bus.en_i & ~bus.we_i;
    assign wr_ctl  = bus.en_i & bus.we_i & (bus.addr_i == REG_CONTROL);
    assign pop     = rd_sel & (bus.addr_i == REG_CODE);
    assign flush   = wr_ctl & bus.din_i[2];
    assign ovf_clr = wr_ctl & bus.din_i[1];
    assign ovf_set = push & full & ~pop & ~flush;
    assign ev      = '{ext: ev_ext, code: rx_code};
    assign head    = kbd_evt_t'(head_raw);

    kbd_event_fifo #(.WIDTH($bits(kbd_evt_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   (ev),
        .head  (head_raw),
        .full  (full),
        .empty (empty)
    );

    assign status = {full, ovf, caps, lalt | ralt, lctrl | rctrl, rshift, lshift, ~empty};

    always_comb begin
        rd_data = 8'h00;
        case (bus.addr_i)
            REG_STATUS:  rd_data = status;
            REG_CODE:    rd_data = empty ? 8'h00 : head.code;
            REG_FLAGS:   rd_data = {7'b0, head.ext & ~empty};
            REG_CONTROL: rd_data = {7'b0, irq_en};
            default:     rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            dout_q <= '0;
            irq_q  <= 1'b0;
            ovf    <= 1'b0;
            irq_en <= IRQ_EN_RST;
        end else begin
            if (rd_sel) dout_q <= rd_data;
            if (wr_ctl) irq_en <= bus.din_i[0];
            ovf   <= (ovf & ~ovf_clr) | ovf_set;
            irq_q <= irq_en & (~empty | ovf);
        end
    end

    assign bus.dout_o = dout_q;
    assign bus.irq_o  = irq_q;
endmodule

// File: tb/tb_ps2_kbd_fifo_ctrl.sv
// Bench for ps2_kbd_fifo_ctrl (FIFO_DEPTH=4): vector table plus hand sequences for
// interrupt and mid-frame reset; queued codes are tracked in a scoreboard queue.
module tb_ps2_kbd_fifo_ctrl;
    import ps2_kbd_fifo_ctrl_pkg::*;

    logic clk = 1'b0, rst = 1'b1, ps2_clk = 1'b1, ps2_din = 1'b1;
    ps2_kbd_fifo_ctrl_if bus ();

    ps2_kbd_fifo_ctrl #(.FIFO_DEPTH(4), .IRQ_EN_RST(1'b0)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .ps2_clk_i (ps2_clk),
        .ps2_din_i (ps2_din),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    typedef enum logic [2:0] {OP_SEND, OP_RD, OP_WR, OP_RDC, OP_RDF} op_t;
    typedef struct {
        op_t        op;
        logic [7:0] a;
        logic [7:0] d;
        logic       q;
        logic [8:0] qe;
        string      name;
    } vec_t;

    vec_t       vecs[$];
    logic [8:0] sb[$];
    int         nvec = 0, nmis = 0;

    function automatic vec_t mkv(op_t op, logic [7:0] a, logic [7:0] d, logic q,
                                 logic [8:0] qe, string name);
        vec_t v;
        v.op = op; v.a = a; v.d = d; v.q = q; v.qe = qe; v.name = name;
        return v;
    endfunction
    function automatic void snd(logic [7:0] b);
        vecs.push_back(mkv(OP_SEND, 8'h00, b, 1'b0, 9'h0, "send"));
    endfunction
    function automatic void sndq(logic [7:0] b, logic ext);
        vecs.push_back(mkv(OP_SEND, 8'h00, b, 1'b1, {ext, b}, "send"));
    endfunction
    function automatic void rd(logic [7:0] a, logic [7:0] e, string n);
        vecs.push_back(mkv(OP_RD, a, e, 1'b0, 9'h0, n));
    endfunction
    function automatic void wr(logic [7:0] a, logic [7:0] d);
        vecs.push_back(mkv(OP_WR, a, d, 1'b0, 9'h0, "write"));
    endfunction
    function automatic void rdc(string n);
        vecs.push_back(mkv(OP_RDC, REG_CODE, 8'h00, 1'b0, 9'h0, n));
    endfunction
    function automatic void rdf(string n);
        vecs.push_back(mkv(OP_RDF, REG_FLAGS, 8'h00, 1'b0, 9'h0, n));
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %02h, expected %02h", name, act, exp);
        end
    endtask

    task automatic ps2_bits(input logic [7:0] b, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, ~^b, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_din = fr[i];
            #50 ps2_clk = 1'b0;
            #100 ps2_clk = 1'b1;
            #50;
        end
        ps2_din = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        ps2_bits(b, 11);
        #300;
    endtask

    task automatic bus_rd(input logic [7:0] a, output logic [7:0] d);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 1'b0; bus.addr_i = a;
        @(negedge clk);
        bus.en_i = 1'b0;
        d = bus.dout_o;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        @(negedge clk);
        bus.en_i = 1'b1; bus.we_i = 1'b1; bus.addr_i = a; bus.din_i = d;
        @(negedge clk);
        bus.en_i = 1'b0; bus.we_i = 1'b0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d, e8;
        logic [8:0] e;

        bus.en_i = 1'b0; bus.we_i = 1'b0; bus.addr_i = '0; bus.din_i = '0;
        repeat (3) @(negedge clk);
        check("rst_dout", bus.dout_o, 8'h00);
        check("rst_irq", {7'b0, bus.irq_o}, 8'h00);
        rst = 1'b0;

        rd(REG_STATUS, 8'h00, "status_reset");
        rd(REG_CONTROL, 8'h00, "control_reset");
        rd(8'h10, 8'h00, "unmapped_read");
        // plain make then break
        sndq(8'h1C, 1'b0); snd(8'hF0); snd(8'h1C);
        rd(REG_STATUS, 8'h01, "t1_status"); rdf("t1_flags"); rdc("t1_code");
        rd(REG_STATUS, 8'h00, "t1_status_empty"); rdc("code_on_empty");
        // left shift held around a key
        snd(8'h12); rd(REG_STATUS, 8'h02, "lshift_set");
        sndq(8'h1C, 1'b0); snd(8'hF0); snd(8'h12);
        rd(REG_STATUS, 8'h01, "lshift_clr"); rdc("t2_code"); rd(REG_STATUS, 8'h00, "t2_empty");
        // extended keys
        snd(8'hE0); sndq(8'h75, 1'b1); snd(8'hE0); snd(8'h14);
        rdf("ext_flags"); rdc("ext_code"); rd(REG_STATUS, 8'h08, "rctrl_set");
        snd(8'hE0); snd(8'hF0); snd(8'h14); rd(REG_STATUS, 8'h00, "rctrl_clr");
        // fake shifts never touch lshift
        snd(8'hE0); snd(8'h12); rd(REG_STATUS, 8'h00, "fake_shift_make");
        snd(8'h12); snd(8'hE0); snd(8'hF0); snd(8'h12);
        rd(REG_STATUS, 8'h02, "fake_brk_keeps_lshift");
        snd(8'hF0); snd(8'h12); rd(REG_STATUS, 8'h00, "lshift_clr2");
        // housekeeping bytes
        snd(8'hAA); snd(8'hFA); snd(8'h00); rd(REG_STATUS, 8'h00, "ignored_codes");
        // alt / right shift
        snd(8'h11); rd(REG_STATUS, 8'h10, "lalt_set");
        snd(8'hE0); snd(8'hF0); snd(8'h11); rd(REG_STATUS, 8'h10, "ralt_brk_keeps_lalt");
        snd(8'hF0); snd(8'h11); rd(REG_STATUS, 8'h00, "lalt_clr");
        snd(8'h59); rd(REG_STATUS, 8'h04, "rshift_set");
        snd(8'hF0); snd(8'h59); rd(REG_STATUS, 8'h00, "rshift_clr");
        // overflow at depth 4
        sndq(8'h1C, 1'b0); sndq(8'h32, 1'b0); sndq(8'h21, 1'b0); sndq(8'h23, 1'b0); snd(8'h24);
        rd(REG_STATUS, 8'hC1, "full_ovf");
        rdc("ovf_code0"); rdc("ovf_code1"); rdc("ovf_code2"); rdc("ovf_code3");
        rd(REG_STATUS, 8'h40, "ovf_sticky");
        wr(REG_CONTROL, 8'h02); rd(REG_STATUS, 8'h00, "ovf_clr");
        rd(REG_CONTROL, 8'h00, "control_bits_read0");
        // caps lock
        sndq(8'h58, 1'b0); rd(REG_STATUS, 8'h21, "caps_on");
        sndq(8'h58, 1'b0); rd(REG_STATUS, 8'h21, "caps_repeat");
        snd(8'hF0); snd(8'h58); rd(REG_STATUS, 8'h21, "caps_release");
        sndq(8'h58, 1'b0); rd(REG_STATUS, 8'h01, "caps_off");
        rdc("caps_code0"); rdc("caps_code1"); rdc("caps_code2");
        rd(REG_STATUS, 8'h00, "caps_empty");
        // flush
        sndq(8'h2B, 1'b0); sndq(8'h34, 1'b0); rd(REG_STATUS, 8'h01, "pre_flush");
        wr(REG_CONTROL, 8'h04); rd(REG_STATUS, 8'h00, "flush"); rdc("flush_code");

        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_SEND: begin
                    send(vecs[i].d);
                    if (vecs[i].q) sb.push_back(vecs[i].qe);
                end
                OP_RD: begin
                    bus_rd(vecs[i].a, d);
                    check(vecs[i].name, d, vecs[i].d);
                end
                OP_WR: begin
                    bus_wr(vecs[i].a, vecs[i].d);
                    if (vecs[i].a == REG_CONTROL && vecs[i].d[2]) sb.delete();
                end
                OP_RDC: begin
                    e8 = 8'h00;
                    if (sb.size() > 0) begin
                        e  = sb.pop_front();
                        e8 = e[7:0];
                    end
                    bus_rd(REG_CODE, d);
                    check(vecs[i].name, d, e8);
                end
                default: begin
                    e8 = 8'h00;
                    if (sb.size() > 0) begin
                        e  = sb[0];
                        e8 = {7'b0, e[8]};
                    end
                    bus_rd(REG_FLAGS, d);
                    check(vecs[i].name, d, e8);
                end
            endcase
        end

        // interrupt raise and clear
        bus_wr(REG_CONTROL, 8'h01);
        bus_rd(REG_CONTROL, d);  check("irq_en_read", d, 8'h01);
        @(negedge clk);          check("irq_idle", {7'b0, bus.irq_o}, 8'h00);
        send(8'h1C); sb.push_back({1'b0, 8'h1C});
        @(negedge clk);          check("irq_set", {7'b0, bus.irq_o}, 8'h01);
        e = sb.pop_front();
        bus_rd(REG_CODE, d);     check("irq_code", d, e[7:0]);
        @(negedge clk);          check("irq_clr", {7'b0, bus.irq_o}, 8'h00);

        // reset in the middle of a frame
        send(8'h1C); sb.push_back({1'b0, 8'h1C});
        bus_rd(REG_STATUS, d);   check("pre_rst_status", d, 8'h01);
        check("pre_rst_irq", {7'b0, bus.irq_o}, 8'h01);
        ps2_bits(8'h4D, 5);
        @(negedge clk); rst = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_dout", bus.dout_o, 8'h00);
        check("midrst_irq", {7'b0, bus.irq_o}, 8'h00);
        rst = 1'b0;
        sb.delete();
        bus_rd(REG_STATUS, d);   check("post_rst_status", d, 8'h00);
        bus_rd(REG_CONTROL, d);  check("post_rst_control", d, 8'h00);
        send(8'h4D); sb.push_back({1'b0, 8'h4D});
        bus_rd(REG_STATUS, d);   check("post_rst_frame_status", d, 8'h01);
        e = sb.pop_front();
        bus_rd(REG_CODE, d);     check("post_rst_frame_code", d, e[7:0]);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end
endmodule
